// File: rtl/turfio_cmd_pkg.sv
// turfio_cmd_pkg: opcodes, run codes, response tags, command field offsets
// and response word builders shared by the TURF command decoder.
package turfio_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_TRIG = 2'b01,
        OP_CTL  = 2'b10,
        OP_RUN  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        RUN_NOP   = 2'b00,
        RUN_START = 2'b01,
        RUN_STOP  = 2'b10,
        RUN_RESET = 2'b11
    } runcode_e;

    localparam logic [3:0] RESP_IDLE = 4'h0;
    localparam logic [3:0] RESP_READ = 4'h5;

    localparam int OPC_LSB   = 30;
    localparam int RDSEL_BIT = 29;
    localparam int ADR_LSB   = 22;
    localparam int DAT_LSB   = 0;
    localparam int RUN_LSB   = 0;
    localparam int ENTRY_W   = 22;

    typedef struct packed {
        logic [5:0]  adr;
        logic [15:0] dat;
    } rd_entry_t;

    function automatic logic [31:0] idle_word(input logic running, input logic ovf,
                                              input logic [4:0] cnt);
        return {RESP_IDLE, 6'b0, running, ovf, 9'b0, cnt, 6'b0};
    endfunction

    function automatic logic [31:0] read_word(input rd_entry_t e, input logic running);
        return {RESP_READ, e.adr, running, 5'b0, e.dat};
    endfunction

endpackage

// File: rtl/turf_resp_fifo.sv
// turf_resp_fifo: synchronous readback FIFO; a pop in the same cycle frees
// room for a push even when full.
module turf_resp_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout    = mem_q[rd_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/turf_command_decoder.sv
// turf_command_decoder: decodes TURF link command words into trigger, run and
// control-register strobes, and builds the slotted response word with queued readbacks.
module turf_command_decoder
    import turfio_cmd_pkg::*;
#(
    parameter int RESP_PERIOD = 8,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic        sync_i,
    input  logic        command_locked_i,
    input  logic [31:0] command_i,
    input  logic        command_valid_i,
    output logic        trig_o,
    output logic [15:0] trig_time_o,
    output logic [1:0]  runcmd_o,
    output logic        runcmd_valid_o,
    output logic        running_o,
    output logic [5:0]  ctl_adr_o,
    output logic [15:0] ctl_dat_o,
    output logic        ctl_we_o,
    output logic        ctl_rd_o,
    input  logic [15:0] ctl_dat_i,
    output logic [31:0] response_o
);
    localparam int SW = $clog2(RESP_PERIOD);

    logic          accept, is_trig, is_ctl, is_run, is_run_reset;
    opcode_e       op;
    runcode_e      rc;
    logic          cmd_unused;

    logic          trig_q, trig_d;
    logic [15:0]   trig_time_q, trig_time_d;
    logic [4:0]    trig_cnt_q, trig_cnt_d;
    logic [1:0]    runcmd_q, runcmd_d;
    logic          runcmd_valid_q, runcmd_valid_d;
    logic          running_q, running_d;
    logic [5:0]    ctl_adr_q, ctl_adr_d;
    logic [15:0]   ctl_dat_q, ctl_dat_d;
    logic          ctl_we_q, ctl_we_d;
    logic          ctl_rd_q, ctl_rd_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   response_q, response_d;
    logic [SW-1:0] slot_q, slot_d, slot_eff;
    logic          slot_upd;

    logic [RD_LATENCY-1:0] pend_v_q, pend_v_d;
    logic [5:0]            pend_adr_q [RD_LATENCY];
    logic [5:0]            pend_adr_d [RD_LATENCY];

    rd_entry_t     fifo_din, fifo_dout;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_set;

    assign cmd_unused = ^{command_i[28], command_i[21:16]};

    always_comb begin
        accept         = command_valid_i && command_locked_i;
        op             = opcode_e'(command_i[OPC_LSB +: 2]);
        rc             = runcode_e'(command_i[RUN_LSB +: 2]);
        is_trig        = accept && op == OP_TRIG;
        is_ctl         = accept && op == OP_CTL;
        is_run         = accept && op == OP_RUN;
        is_run_reset   = is_run && rc == RUN_RESET;
        trig_d         = is_trig;
        trig_time_d    = is_trig ? command_i[DAT_LSB +: 16] : trig_time_q;
        trig_cnt_d     = is_trig ? trig_cnt_q + 5'd1 : is_run_reset ? 5'd0 : trig_cnt_q;
        ctl_adr_d      = is_ctl ? command_i[ADR_LSB +: 6] : ctl_adr_q;
        ctl_dat_d      = is_ctl ? command_i[DAT_LSB +: 16] : ctl_dat_q;
        ctl_we_d       = is_ctl && !command_i[RDSEL_BIT];
        ctl_rd_d       = is_ctl && command_i[RDSEL_BIT];
        runcmd_d       = is_run ? command_i[RUN_LSB +: 2] : runcmd_q;
        runcmd_valid_d = is_run;
        running_d      = (is_run && rc == RUN_START) ? 1'b1 :
                         (is_run && (rc == RUN_STOP || rc == RUN_RESET)) ? 1'b0 : running_q;
    end

    // The read strobe and its address enter the delay line together; the tail
    // lines up with the cycle ctl_dat_i is valid.
    always_comb begin
        pend_v_d[0]   = ctl_rd_q;
        pend_adr_d[0] = ctl_adr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pend_v_d[i]   = pend_v_q[i-1];
            pend_adr_d[i] = pend_adr_q[i-1];
        end
        fifo_push  = pend_v_q[RD_LATENCY-1];
        fifo_din   = {pend_adr_q[RD_LATENCY-1], ctl_dat_i};
        slot_eff   = sync_i ? '0 : slot_q;
        slot_upd   = slot_eff == '0;
        slot_d     = slot_eff + SW'(1);
        fifo_pop   = slot_upd && !fifo_empty;
        ovf_set    = fifo_push && fifo_full && !fifo_pop;
        ovf_d      = ovf_set || (ovf_q && !is_run_reset);
        response_d = !slot_upd ? response_q :
                     fifo_empty ? idle_word(running_q, ovf_q, trig_cnt_q) :
                     read_word(fifo_dout, running_q);
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            trig_q         <= 1'b0;
            trig_time_q    <= '0;
            trig_cnt_q     <= '0;
            runcmd_q       <= '0;
            runcmd_valid_q <= 1'b0;
            running_q      <= 1'b0;
            ctl_adr_q      <= '0;
            ctl_dat_q      <= '0;
            ctl_we_q       <= 1'b0;
            ctl_rd_q       <= 1'b0;
            ovf_q          <= 1'b0;
            response_q     <= '0;
            slot_q         <= '0;
            pend_v_q       <= '0;
            pend_adr_q     <= '{default: '0};
        end else begin
            trig_q         <= trig_d;
            trig_time_q    <= trig_time_d;
            trig_cnt_q     <= trig_cnt_d;
            runcmd_q       <= runcmd_d;
            runcmd_valid_q <= runcmd_valid_d;
            running_q      <= running_d;
            ctl_adr_q      <= ctl_adr_d;
            ctl_dat_q      <= ctl_dat_d;
            ctl_we_q       <= ctl_we_d;
            ctl_rd_q       <= ctl_rd_d;
            ovf_q          <= ovf_d;
            response_q     <= response_d;
            slot_q         <= slot_d;
            pend_v_q       <= pend_v_d;
            pend_adr_q     <= pend_adr_d;
        end
    end

    turf_resp_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk_i),
        .rst   (sysclk_rst_i),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trig_o         = trig_q;
    assign trig_time_o    = trig_time_q;
    assign runcmd_o       = runcmd_q;
    assign runcmd_valid_o = runcmd_valid_q;
    assign running_o      = running_q;
    assign ctl_adr_o      = ctl_adr_q;
    assign ctl_dat_o      = ctl_dat_q;
    assign ctl_we_o       = ctl_we_q;
    assign ctl_rd_o       = ctl_rd_q;
    assign response_o     = response_q;

endmodule

// File: tb/tb_turf_command_decoder.sv
// tb_turf_command_decoder: directed and random command streams scored against a
// queue-based reference model; a negedge monitor pops expected events and compares.
module tb_turf_command_decoder;
    localparam int P = 8;
    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, sync = 1'b0, locked = 1'b0, valid = 1'b0;
    logic [31:0] cmd = '0;
    logic [15:0] rd_dat = '0;
    logic        trig_o, runcmd_valid_o, running_o, ctl_we_o, ctl_rd_o;
    logic [15:0] trig_time_o, ctl_dat_o;
    logic [1:0]  runcmd_o;
    logic [5:0]  ctl_adr_o;
    logic [31:0] response_o;

    always #5 clk = ~clk;

    turf_command_decoder #(
        .RESP_PERIOD (P),
        .RD_LATENCY  (L),
        .FIFO_DEPTH  (D)
    ) dut (
        .sysclk_i         (clk),
        .sysclk_rst_i     (rst),
        .sync_i           (sync),
        .command_locked_i (locked),
        .command_i        (cmd),
        .command_valid_i  (valid),
        .trig_o           (trig_o),
        .trig_time_o      (trig_time_o),
        .runcmd_o         (runcmd_o),
        .runcmd_valid_o   (runcmd_valid_o),
        .running_o        (running_o),
        .ctl_adr_o        (ctl_adr_o),
        .ctl_dat_o        (ctl_dat_o),
        .ctl_we_o         (ctl_we_o),
        .ctl_rd_o         (ctl_rd_o),
        .ctl_dat_i        (rd_dat),
        .response_o       (response_o)
    );

    typedef struct { int e; logic [63:0] v; } exp_t;
    typedef struct { int due; logic [5:0] adr; logic [15:0] dat; } rd_t;

    exp_t trq[$], rnq[$], ctq[$], rsq[$];
    rd_t  pend[$], mfifo[$];
    bit   m_run, m_ovf, mon_en;
    int   m_cnt, m_slot;
    int   checks = 0, failures = 0, scyc = 0, mcyc = 0;
    logic [15:0] rd_pick = 16'h0;
    logic [31:0] cur_resp = '0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, mcyc, a, x);
        end
    endtask

    // Reference: inputs sampled at edge e; expected outputs are those seen just after e.
    task automatic model(input int e);
        int  eff;
        bit  set_ovf;
        rd_t r;
        set_ovf = 0;
        if (rst) begin
            m_run = 0; m_ovf = 0; m_cnt = 0; m_slot = 0;
            mfifo.delete(); pend.delete();
            rsq.push_back('{e, 64'd0});
            return;
        end
        eff = sync ? 0 : m_slot;
        m_slot = (eff + 1) % P;
        if (eff == 0) begin
            if (mfifo.size() > 0) begin
                r = mfifo.pop_front();
                rsq.push_back('{e, 64'(32'h5000_0000 + (int'(r.adr) << 22) + (int'(m_run) << 21) + int'(r.dat))});
            end else
                rsq.push_back('{e, 64'((int'(m_run) << 21) + (int'(m_ovf) << 20) + (m_cnt << 6))});
        end
        if (pend.size() > 0 && pend[0].due == e) begin
            r = pend.pop_front();
            if (mfifo.size() < D) mfifo.push_back(r);
            else set_ovf = 1;
        end
        if (valid && locked) begin
            if (cmd[31:30] == 2'b01) begin
                trq.push_back('{e, 64'(cmd[15:0])});
                m_cnt = (m_cnt + 1) % 32;
            end else if (cmd[31:30] == 2'b10) begin
                ctq.push_back('{e, 64'({!cmd[29], cmd[29], cmd[27:22], cmd[15:0]})});
                if (cmd[29]) pend.push_back('{e + L + 1, cmd[27:22], rd_pick});
            end else if (cmd[31:30] == 2'b11) begin
                if (cmd[1:0] == 2'b01) m_run = 1;
                if (cmd[1:0] == 2'b10) m_run = 0;
                if (cmd[1:0] == 2'b11) begin m_run = 0; m_cnt = 0; m_ovf = 0; end
                rnq.push_back('{e, 64'({cmd[1:0], m_run})});
            end
        end
        if (set_ovf) m_ovf = 1;
    endtask

    task automatic tick(input bit v, input bit lk, input logic [31:0] c, input bit s);
        valid = v; locked = lk; cmd = c; sync = s;
        rd_dat = (pend.size() > 0 && pend[0].due == scyc + 1) ? pend[0].dat : 16'($urandom);
        model(scyc + 1);
        rd_pick = 16'($urandom);
        @(posedge clk);
        scyc++;
        #1;
    endtask

    task automatic mon();
        exp_t x;
        if (trq.size() > 0 && trq[0].e == mcyc) begin
            x = trq.pop_front();
            chk("trig", 64'({trig_o, trig_time_o}), 64'({1'b1, x.v[15:0]}));
        end else chk("trig_quiet", 64'(trig_o), 64'd0);
        if (rnq.size() > 0 && rnq[0].e == mcyc) begin
            x = rnq.pop_front();
            chk("run", 64'({runcmd_valid_o, runcmd_o, running_o}), 64'({1'b1, x.v[2:0]}));
        end else chk("run_quiet", 64'(runcmd_valid_o), 64'd0);
        if (ctq.size() > 0 && ctq[0].e == mcyc) begin
            x = ctq.pop_front();
            chk("ctl", 64'({ctl_we_o, ctl_rd_o, ctl_adr_o, ctl_dat_o}), 64'(x.v[23:0]));
        end else chk("ctl_quiet", 64'({ctl_we_o, ctl_rd_o}), 64'd0);
        if (rsq.size() > 0 && rsq[0].e == mcyc) begin
            x = rsq.pop_front();
            cur_resp = x.v[31:0];
            chk("resp_slot", 64'(response_o), 64'(cur_resp));
        end else chk("resp_hold", 64'(response_o), 64'(cur_resp));
    endtask

    always @(posedge clk) mcyc <= mcyc + 1;

    initial forever begin
        @(negedge clk);
        if (mon_en) mon();
    end

    initial begin
        logic [31:0] c;
        rst = 1;
        tick(0, 0, 32'h0, 0);
        mon_en = 1;
        repeat (2) tick(0, 0, 32'h0, 0);
        rst = 0;
        tick(0, 1, 32'h0, 1);
        repeat (20) tick(0, 1, 32'h0, 0);
        tick(1, 1, 32'h4000_1234, 0);
        repeat (10) tick(0, 1, 32'h0, 0);
        tick(1, 1, 32'h8140_BEEF, 0);
        repeat (4) tick(0, 1, 32'h0, 0);
        rd_pick = 16'hCAFE;
        tick(1, 1, 32'hA1C0_0000, 0);
        repeat (16) tick(0, 1, 32'h0, 0);
        for (int k = 0; k < 5; k++) begin
            c = 32'hA000_0000 | (32'(k + 8) << 22) | 32'(k);
            tick(1, 1, c, k == 0);
        end
        repeat (50) tick(0, 1, 32'h0, 0);
        tick(1, 1, 32'hC000_0003, 0);
        repeat (10) tick(0, 1, 32'h0, 0);
        tick(1, 0, 32'h4000_0042, 0);
        tick(1, 0, 32'hC000_0001, 0);
        repeat (3) tick(0, 1, 32'h0, 0);
        tick(1, 1, 32'hC000_0001, 0);
        repeat (10) tick(0, 1, 32'h0, 0);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            c = $urandom;
            if (i % 400 < 40) c[31:29] = 3'b101;
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, c, $urandom_range(0, 39) == 0);
        end
        rst = 0;
        repeat (60) tick(0, 1, 32'h0, 0);
        @(negedge clk);
        #1;
        chk("drain_trig", 64'(trq.size()), 64'd0);
        chk("drain_run", 64'(rnq.size()), 64'd0);
        chk("drain_ctl", 64'(ctq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
